// File: rtl/mult_149_limb_acc.sv
// Accumulates up to four 197-bit limb partial products into a 298-bit product; result valid one cycle after the last limb.
// Holds the result with in_ready low until out_ready; MULT_ACC_OVF_CHECK_EN adds a sticky ovf flag.
module mult_149_limb_acc (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [196:0]   in_p,
   input  logic           in_last,
   output logic           out_valid,
   input  logic           out_ready,
`ifdef MULT_ACC_OVF_CHECK_EN
   output logic           ovf,
`endif
   output logic [297:0]   out_prod
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   logic [1:0]     k;
   logic [297:0]   acc;
   logic [7:0]     shamt;
   logic [297:0]   shifted_lo;
   logic [297:0]   acc_sum;
   logic           xfer;
   logic           finish;

   assign xfer   = in_valid && in_ready;
   assign finish = in_last || (k == 2'd3);
   assign shamt  = 8'(k) * 8'd48;

`ifdef MULT_ACC_OVF_CHECK_EN
   // Shift into a wide word so limb bits pushed past bit 297 stay visible.
   logic [340:0]   wide;
   logic           carry;
   logic           ovf_now;

   assign wide       = {144'b0, in_p} << shamt;
   assign shifted_lo = wide[297:0];
   assign {carry, acc_sum} = {1'b0, acc} + {1'b0, shifted_lo};
   assign ovf_now    = (k != 2'd0) &&
                       ((|wide[340:298]) || carry || ((k == 2'd3) && !in_last));
`else
   assign shifted_lo = {101'b0, in_p} << shamt;
   assign acc_sum    = acc + shifted_lo;
`endif

   assign out_prod = acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= 2'd0;
         acc       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef MULT_ACC_OVF_CHECK_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, ACC: begin
               if (xfer) begin
                  // First limb replaces whatever the accumulator held.
                  acc <= (k == 2'd0) ? {101'b0, in_p} : acc_sum;
`ifdef MULT_ACC_OVF_CHECK_EN
                  if (ovf_now) begin
                     ovf <= 1'b1;
                  end
`endif
                  if (finish) begin
                     state     <= DONE;
                     k         <= 2'd0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ACC;
                     k     <= k + 2'd1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  k         <= 2'd0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               k         <= 2'd0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_149_limb_acc.sv
// Scoreboard bench for mult_149_limb_acc: directed limb sequences with hand-derived products.
module tb_mult_149_limb_acc;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [196:0]   in_p;
   logic           in_last;
   logic           out_valid;
   logic           out_ready;
   logic [297:0]   out_prod;
`ifdef MULT_ACC_OVF_CHECK_EN
   logic           ovf;
`endif

   int total = 0;
   int bad   = 0;
   logic [297:0] exp_q[$];

   always #5 clk = ~clk;

   mult_149_limb_acc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p      (in_p),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef MULT_ACC_OVF_CHECK_EN
      .ovf       (ovf),
`endif
      .out_prod  (out_prod)
   );

   task automatic chk(input string name, input logic [297:0] act, input logic [297:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Monitor: compares every presented result against the queue head, pops on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out got=%h want=none", out_prod);
         end else begin
            chk("out_prod", out_prod, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [196:0] p, input logic last);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_p     = p;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 298'(in_ready), 298'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [196:0] a_full;
   logic [196:0] p_lo;
   logic [196:0] p_hi;
   logic [297:0] exp_full;
   logic [297:0] exp_four;
   logic [196:0] big;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_p      = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick(2);
      rst = 1'b0;
      chk("rst_in_ready", 298'(in_ready), 298'd1);
      chk("rst_out_valid", 298'(out_valid), 298'd0);
      chk("rst_acc", out_prod, 298'd0);
`ifdef MULT_ACC_OVF_CHECK_EN
      chk("rst_ovf", 298'(ovf), 298'd0);
`endif

      // Single limb: result one cycle after the transfer, then valid falls.
      exp_q.push_back(298'd5);
      send(197'd5, 1'b1);
      chk("lat1_valid", 298'(out_valid), 298'd1);
      chk("lat1_in_ready", 298'(in_ready), 298'd0);
      tick(1);
      chk("lat1_valid_fall", 298'(out_valid), 298'd0);
      chk("lat1_in_ready_back", 298'(in_ready), 298'd1);

      // Four unit limbs land at 0, 48, 96, 144.
      exp_four = (298'd1) | (298'd1 << 48) | (298'd1 << 96) | (298'd1 << 144);
      exp_q.push_back(exp_four);
      send(197'd1, 1'b0);
      send(197'd1, 1'b0);
      send(197'd1, 1'b0);
      send(197'd1, 1'b1);
      tick(2);

      // Full range: a = 2^149-1, limbs 2^48-1 (x3) and 2^5-1; product = 2^298 - 2^150 + 1.
      a_full   = (197'd1 << 149) - 197'd1;
      p_lo     = (a_full << 48) - a_full;
      p_hi     = (a_full << 5) - a_full;
      exp_full = ~298'd0 - (298'd1 << 150) + 298'd2;
      exp_q.push_back(exp_full);
      send(p_lo, 1'b0);
      send(p_lo, 1'b0);
      send(p_lo, 1'b0);
      send(p_hi, 1'b1);
`ifdef MULT_ACC_OVF_CHECK_EN
      chk("full_ovf", 298'(ovf), 298'd0);
`endif
      tick(2);

      // Backpressure: result held for three cycles, input pulses refused.
      out_ready = 1'b0;
      exp_q.push_back(298'd2 + (298'd3 << 48));
      send(197'd2, 1'b0);
      send(197'd3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_p     = 197'h1234 + 197'(i);
         in_last  = 1'b1;
         @(negedge clk);
         chk("bp_in_ready", 298'(in_ready), 298'd0);
         chk("bp_valid", 298'(out_valid), 298'd1);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick(1);
      chk("bp_release_valid", 298'(out_valid), 298'd0);
      chk("bp_release_ready", 298'(in_ready), 298'd1);

      // Reset mid-operation discards the partial sum.
      send(197'd9, 1'b0);
      send(197'd10, 1'b0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst_valid", 298'(out_valid), 298'd0);
      chk("midrst_ready", 298'(in_ready), 298'd1);
      exp_q.push_back(298'd7);
      send(197'd7, 1'b1);
      tick(2);

      // Fourth limb without last ends anyway; 2^196 << 144 falls off the top.
      big = 197'd1 << 196;
      exp_q.push_back(298'd0);
      out_ready = 1'b0;
      send(197'd0, 1'b0);
      send(197'd0, 1'b0);
      send(197'd0, 1'b0);
      send(big, 1'b0);
      chk("implicit_last_valid", 298'(out_valid), 298'd1);
`ifdef MULT_ACC_OVF_CHECK_EN
      chk("ovf_set", 298'(ovf), 298'd1);
`endif
      out_ready = 1'b1;
      tick(3);
`ifdef MULT_ACC_OVF_CHECK_EN
      chk("ovf_sticky", 298'(ovf), 298'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("ovf_cleared", 298'(ovf), 298'd0);
`endif

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
      chk("queue_drained", 298'(exp_q.size()), 298'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
